// File: rtl/id_decode_stage.sv
// ID stage: holds the fetched word with its PC, decodes B/J control-transfer info for IF,
// and registers the instruction across the ID/EX boundary with stall, redirect and flush handling.
//
// state | meaning
// RUN   | ID source is the live instruction-memory read data
// HOLD  | stalled; ID source is the word captured when the stall began
module id_decode_stage #(
  parameter logic [31:0] NOP         = 32'h0000_0013,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            inst_mem_read_addr,
  input  logic [31:0]            inst_mem_read_data,
  input  logic                   EX_stall,
  input  logic                   EX_mispredict,
  output logic                   ID_valid,
  output logic [31:0]            ID_pc,
  output logic [31:0]            ID_inst,
  output logic                   ID_branch,
  output logic                   ID_unconditional_jmp,
  output logic [31:0]            ID_imme,
  output logic                   EX_valid,
  output logic [31:0]            EX_pc,
  output logic [31:0]            EX_inst,
  output logic [31:0]            EX_imme,
  output logic [COUNT_WIDTH-1:0] ID_branch_count,
  output logic [COUNT_WIDTH-1:0] ID_flush_count
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] hold_inst;
  logic [31:0] src_inst;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_cond_branch;

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] cnt,
                                                     input logic [1:0]             inc);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(COUNT_WIDTH-1){1'b0}}, inc};
    return sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
  endfunction

  assign ID_valid = valid_q;
  assign ID_pc    = pc_q;

  always_comb begin
    src_inst             = (state_q == HOLD) ? hold_inst : inst_mem_read_data;
    ID_inst              = valid_q ? src_inst : NOP;
    b_imm                = {{20{ID_inst[31]}}, ID_inst[7], ID_inst[30:25], ID_inst[11:8], 1'b0};
    j_imm                = {{12{ID_inst[31]}}, ID_inst[19:12], ID_inst[20], ID_inst[30:21], 1'b0};
    is_cond_branch       = valid_q && (ID_inst[6:0] == OP_BRANCH);
    ID_unconditional_jmp = valid_q && (ID_inst[6:0] == OP_JAL);
    ID_branch            = is_cond_branch || ID_unconditional_jmp;
    ID_imme              = 32'h0;
    if (is_cond_branch)
      ID_imme = b_imm;
    else if (ID_unconditional_jmp)
      ID_imme = j_imm;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= RUN;
      pc_q            <= 32'h0;
      valid_q         <= 1'b0;
      hold_inst       <= NOP;
      EX_valid        <= 1'b0;
      EX_pc           <= 32'h0;
      EX_inst         <= NOP;
      EX_imme         <= 32'h0;
      ID_branch_count <= '0;
      ID_flush_count  <= '0;
    end else if (EX_stall) begin
      EX_valid <= 1'b0;
      EX_inst  <= NOP;
      // Capture only on stall entry; later cycles keep the original word.
      if (state_q == RUN) begin
        hold_inst <= inst_mem_read_data;
        state_q   <= HOLD;
      end
    end else if (EX_mispredict) begin
      EX_valid       <= 1'b0;
      EX_inst        <= NOP;
      pc_q           <= inst_mem_read_addr;
      valid_q        <= 1'b0;
      state_q        <= RUN;
      ID_flush_count <= sat_add(ID_flush_count, 2'd2);
    end else begin
      EX_valid <= valid_q;
      EX_pc    <= pc_q;
      EX_inst  <= ID_inst;
      EX_imme  <= ID_imme;
      pc_q     <= inst_mem_read_addr;
      // After a redirect the next arriving word is the fall-through fetch.
      valid_q  <= !ID_branch;
      state_q  <= RUN;
      if (ID_branch)
        ID_flush_count <= sat_add(ID_flush_count, 2'd1);
      if (is_cond_branch)
        ID_branch_count <= sat_add(ID_branch_count, 2'd1);
    end
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Instruction-decode front end that sits directly downstream of the IF stage. It captures the word returned by the synchronous instruction memory and tags it with its fetch PC. It decodes the B/J-type control-transfer information that IF consumes (ID_branch, ID_unconditional_jmp, ID_imme). It then registers the decoded instruction into the ID/EX boundary, handling load-use stalls, redirect squashes and EX mispredict flushes.

## Interface
- NOP, 32'h0000_0013, word injected into the EX register for a bubble
- COUNT_WIDTH, 16, width of the saturating performance counters

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values
- inst_mem_read_addr  in  32  current IF PC (the address presented to memory this cycle)
- inst_mem_read_data  in  32  memory word for the address presented in the previous cycle
- EX_stall  in  1  load-use stall; ID holds and EX receives a bubble
- EX_mispredict  in  1  EX resolved a conditional branch opposite to its prediction
- ID_valid  out  1  ID slot holds a live instruction
- ID_pc  out  32  fetch PC of the ID instruction
- ID_inst  out  32  ID instruction word (NOP when !ID_valid)
- ID_branch  out  1  ID_valid and opcode is BRANCH (1100011) or JAL (1101111)
- ID_unconditional_jmp  out  1  ID_valid and opcode is JAL
- ID_imme  out  32  sign-extended B/J immediate, 0 for other opcodes or when invalid
- EX_valid  out  1  registered ID_valid
- EX_pc  out  32  registered ID_pc
- EX_inst  out  32  registered ID_inst
- EX_imme  out  32  registered ID_imme
- ID_branch_count  out  COUNT_WIDTH  conditional branches delivered to EX
- ID_flush_count  out  COUNT_WIDTH  instruction slots squashed

## Operation
- Internal state: pc_q (32), valid_q, hold_inst (32), state in {RUN, HOLD}.
- Instruction source: hold_inst when state==HOLD, otherwise inst_mem_read_data.
- ID_inst is the source word when valid_q is 1, and NOP otherwise. ID_pc is pc_q. ID_valid is valid_q.
- B immediate: {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}.
- J immediate: {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
- JALR and all other opcodes assert neither ID_branch nor ID_unconditional_jmp.
- Per-edge priority, highest first: reset, EX_stall, EX_mispredict, ID redirect (ID_branch=1), normal advance.
- EX_stall:
  - pc_q and valid_q hold.
  - EX_valid<=0 and EX_inst<=NOP; the other EX fields hold.
  - In RUN: hold_inst<=inst_mem_read_data and state<=HOLD.
  - In HOLD: everything holds.
- EX_mispredict (no stall):
  - EX gets a bubble (the ID instruction is wrong-path).
  - pc_q<=inst_mem_read_addr and valid_q<=0.
  - state<=RUN.
  - flush_count += 2.
- ID redirect (no stall, no mispredict):
  - EX<=ID fields with EX_valid=1.
  - pc_q<=inst_mem_read_addr and valid_q<=0, because the word arriving next cycle is the fall-through fetch.
  - state<=RUN; flush_count += 1.
  - Conditional branches (not JAL) also increment branch_count.
- Normal advance:
  - EX<=ID fields.
  - pc_q<=inst_mem_read_addr and valid_q<=1.
  - state<=RUN.
- HOLD exit: the first non-stalled cycle still presents hold_inst. At that cycle's edge the block advances normally and returns to RUN.
- Counters saturate at all-ones and never wrap.
- EX_mispredict is ignored while EX_stall=1. Upstream re-presents it after the stall.

## Timing
- Reset values:
  - pc_q=0, valid_q=0, state=RUN, hold_inst=NOP.
  - EX_valid=0, EX_pc=0, EX_inst=NOP, EX_imme=0.
  - Both counters 0.
  - All ID_* outputs therefore read invalid, NOP or 0.
- Decode is combinational from the source word. ID_branch, ID_unconditional_jmp and ID_imme are valid in the same cycle the word arrives.
  - While ID holds the word fetched from address A, IF's PC is A+4, so ID_pc equals IF's PC minus 4.
- ID-to-EX latency is 1 cycle.
- Redirect squash costs 1 slot; a mispredict costs 2 slots.
- First post-reset cycle: ID is invalid. In the second cycle ID shows address 0 with ID_valid=1.
- Reset asserted mid-HOLD returns immediately to RUN with all outputs at their reset values.
- ID_branch remains asserted during a stall. IF ignores it then and acts on it in the release cycle.

## Test plan
- Reset release, memory returns sequential ADDI words → ID_pc 0,4,8 on consecutive cycles starting in cycle 2; EX follows 1 cycle later; no counts.
- BEQ 32'h0000_0863 at pc 8 → ID_branch=1, ID_unconditional_jmp=0, ID_imme=16. The next ID slot is invalid. branch_count=1, flush_count=1.
- JAL 32'hFF9F_F0EF at pc 0x20 → ID_branch=1, ID_unconditional_jmp=1, ID_imme=0xFFFF_FFF8. The next slot is squashed; branch_count is unchanged.
- EX_stall for 3 cycles while ID shows the word at pc 12 and memory data changes → ID_inst and ID_pc stay at pc 12. EX_valid=0 for 3 cycles. After release, EX_pc=12, then ID shows pc 16.
- EX_mispredict pulse while ID is valid → EX_valid=0 the next cycle, ID_valid=0 the next cycle, flush_count += 2. A mispredict coincident with EX_stall has no effect.
- Drive 2^16+5 redirects → flush_count saturates at 0xFFFF. Asserting reset low mid-stall clears the counters and the EX/ID outputs asynchronously.
